// File: rtl/sync_multi.sv
// Multi-channel input synchroniser: per-channel flop chain, glitch filter and
// registered rise/fall strobes, plus a registered any-change flag across channels.

module sync_multi_lane #(
    parameter int   STAGES     = 2,
    parameter int   FILTER_LEN = 1,
    parameter int   CNT_W      = 1,
    parameter logic RST_BIT    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic chg_nxt
);
    logic [STAGES-1:0] stage;
    logic [CNT_W-1:0]  cnt;
    logic              raw;
    logic              flip;

    assign raw     = stage[STAGES-1];
    // sync_out adopts raw only after FILTER_LEN consecutive mismatching cycles
    assign flip    = (raw != sync_out) && (cnt == CNT_W'(FILTER_LEN - 1));
    assign chg_nxt = flip;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage      <= {STAGES{RST_BIT}};
            sync_out   <= RST_BIT;
            cnt        <= '0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            stage      <= {stage[STAGES-2:0], async_in};
            rise_pulse <= flip & raw;
            fall_pulse <= flip & ~raw;
            if (raw == sync_out) begin
                cnt <= '0;
            end else if (flip) begin
                sync_out <= raw;
                cnt      <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module sync_multi #(
    parameter int               WIDTH      = 1,
    parameter int               STAGES     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}},
    parameter int               FILTER_LEN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_change
);
    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic [WIDTH-1:0] chg_nxt;

    if (STAGES < 2 || STAGES > 8) begin : g_bad_stages
        $error("sync_multi: STAGES must be in 2..8");
    end
    if (FILTER_LEN < 1 || FILTER_LEN > 255) begin : g_bad_filter
        $error("sync_multi: FILTER_LEN must be in 1..255");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        sync_multi_lane #(
            .STAGES    (STAGES),
            .FILTER_LEN(FILTER_LEN),
            .CNT_W     (CNT_W),
            .RST_BIT   (RESET_VAL[i])
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .async_in  (async_in[i]),
            .sync_out  (sync_out[i]),
            .rise_pulse(rise_pulse[i]),
            .fall_pulse(fall_pulse[i]),
            .chg_nxt   (chg_nxt[i])
        );
    end

    // Registered from the lanes' next-cycle flip so it lines up with the pulses
    always_ff @(posedge clk) begin
        if (rst) any_change <= 1'b0;
        else     any_change <= |chg_nxt;
    end
endmodule

// File: tb/tb_sync_multi.sv
// Self-checking bench for sync_multi: 4-channel filtered instance plus a
// minimal 1-channel instance, expectations queued per cycle and popped after each edge.

module tb_sync_multi;
    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [3:0] a_in = 4'b1010;
    logic [3:0] so, rp, fp;
    logic       ac;

    logic       rst_s = 1'b1;
    logic       a_s   = 1'b0;
    logic       so_s, rp_s, fp_s, ac_s;

    int checks = 0;
    int errors = 0;

    logic [12:0] exp_q[$];
    logic [3:0]  exp_s[$];

    sync_multi #(.WIDTH(4), .STAGES(3), .RESET_VAL(4'b0101), .FILTER_LEN(4)) dut (
        .clk(clk), .rst(rst), .async_in(a_in), .sync_out(so),
        .rise_pulse(rp), .fall_pulse(fp), .any_change(ac)
    );

    sync_multi #(.WIDTH(1), .STAGES(2), .RESET_VAL(1'b0), .FILTER_LEN(1)) dut_s (
        .clk(clk), .rst(rst_s), .async_in(a_s), .sync_out(so_s),
        .rise_pulse(rp_s), .fall_pulse(fp_s), .any_change(ac_s)
    );

    function automatic logic [12:0] pk(logic [3:0] s, logic [3:0] r, logic [3:0] f, logic a);
        return {s, r, f, a};
    endfunction

    task automatic test_reset();
        logic [12:0] e, got;
        rst  = 1'b1;
        a_in = 4'b1010;
        for (int k = 1; k <= 2; k++) begin
            exp_q.push_back(pk(4'b0101, 4'b0000, 4'b0000, 1'b0));
            @(posedge clk); #1;
            got = {so, rp, fp, ac};
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset k=%0d got=%b exp=%b", k, got, e);
            end
        end
        rst  = 1'b0;
        a_in = 4'b0111;
    endtask

    task automatic test_step();
        logic [12:0] e, got;
        for (int k = 1; k <= 8; k++) begin
            exp_q.push_back(pk((k >= 7) ? 4'b0111 : 4'b0101,
                               (k == 7) ? 4'b0010 : 4'b0000, 4'b0000, k == 7));
            @(posedge clk); #1;
            got = {so, rp, fp, ac};
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL step k=%0d got=%b exp=%b", k, got, e);
            end
        end
    endtask

    task automatic test_glitch();
        logic [12:0] e, got;
        // 3-cycle low pulse on channel 0 is shorter than the filter
        for (int k = 1; k <= 10; k++) begin
            a_in = (k <= 3) ? 4'b0110 : 4'b0111;
            exp_q.push_back(pk(4'b0111, 4'b0000, 4'b0000, 1'b0));
            @(posedge clk); #1;
            got = {so, rp, fp, ac};
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL glitch3 k=%0d got=%b exp=%b", k, got, e);
            end
        end
        // 4-cycle low pulse passes: fall at edge 7, rise 7 edges after restore
        for (int k = 1; k <= 14; k++) begin
            a_in = (k <= 4) ? 4'b0110 : 4'b0111;
            exp_q.push_back(pk((k >= 7 && k < 11) ? 4'b0110 : 4'b0111,
                               (k == 11) ? 4'b0001 : 4'b0000,
                               (k == 7)  ? 4'b0001 : 4'b0000,
                               k == 7 || k == 11));
            @(posedge clk); #1;
            got = {so, rp, fp, ac};
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL glitch4 k=%0d got=%b exp=%b", k, got, e);
            end
        end
    endtask

    task automatic test_simul();
        logic [12:0] e, got;
        a_in = 4'b1011;
        for (int k = 1; k <= 9; k++) begin
            exp_q.push_back(pk((k >= 7) ? 4'b1011 : 4'b0111,
                               (k == 7) ? 4'b1000 : 4'b0000,
                               (k == 7) ? 4'b0100 : 4'b0000, k == 7));
            @(posedge clk); #1;
            got = {so, rp, fp, ac};
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL simul_a k=%0d got=%b exp=%b", k, got, e);
            end
        end
        a_in = 4'b0111;
        for (int k = 1; k <= 9; k++) begin
            exp_q.push_back(pk((k >= 7) ? 4'b0111 : 4'b1011,
                               (k == 7) ? 4'b0100 : 4'b0000,
                               (k == 7) ? 4'b1000 : 4'b0000, k == 7));
            @(posedge clk); #1;
            got = {so, rp, fp, ac};
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL simul_b k=%0d got=%b exp=%b", k, got, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [12:0] e, got;
        // channel 0 mismatch counted twice (cnt=2) before reset hits
        a_in = 4'b0110;
        for (int k = 1; k <= 5; k++) begin
            exp_q.push_back(pk(4'b0111, 4'b0000, 4'b0000, 1'b0));
            @(posedge clk); #1;
            got = {so, rp, fp, ac};
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL rmid_pre k=%0d got=%b exp=%b", k, got, e);
            end
        end
        rst = 1'b1;
        exp_q.push_back(pk(4'b0101, 4'b0000, 4'b0000, 1'b0));
        @(posedge clk); #1;
        got = {so, rp, fp, ac};
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL rmid_rst got=%b exp=%b", got, e);
        end
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            exp_q.push_back(pk((k >= 7) ? 4'b0110 : 4'b0101,
                               (k == 7) ? 4'b0010 : 4'b0000,
                               (k == 7) ? 4'b0001 : 4'b0000, k == 7));
            @(posedge clk); #1;
            got = {so, rp, fp, ac};
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL rmid_post k=%0d got=%b exp=%b", k, got, e);
            end
        end
    endtask

    task automatic test_small();
        logic [3:0] e, got;
        logic s_now, s_prev;
        rst_s = 1'b1;
        a_s   = 1'b0;
        exp_s.push_back(4'b0000);
        @(posedge clk); #1;
        got = {so_s, rp_s, fp_s, ac_s};
        e = exp_s.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL small_rst got=%b exp=%b", got, e);
        end
        rst_s = 1'b0;
        // input toggles every 4 cycles; sync_out follows 3 edges after each change
        for (int j = 0; j < 20; j++) begin
            a_s    = ((j / 4) % 2) == 1;
            s_now  = (j >= 2) && (((j - 2) / 4) % 2 == 1);
            s_prev = (j >= 3) && (((j - 3) / 4) % 2 == 1);
            exp_s.push_back({s_now, s_now & ~s_prev, ~s_now & s_prev, s_now ^ s_prev});
            @(posedge clk); #1;
            got = {so_s, rp_s, fp_s, ac_s};
            e = exp_s.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL small j=%0d got=%b exp=%b", j, got, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_step();
        test_glitch();
        test_simul();
        test_reset_mid();
        test_small();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sync_multi.md
Name: sync_multi

Overview:
- Parametrised multi-channel input synchroniser: configurable chain depth, per-channel reset value, a per-channel glitch filter, and registered rise/fall edge pulses.
- Sits at the boundary between asynchronous pins (TDI/TMS-style inputs, straps, external flags) and core logic.
- Replaces ad-hoc two-flop synchronisers wherever downstream logic needs clean, debounced levels plus single-cycle edge strobes.

Parameters:
- WIDTH, 1: number of independent channels.
- STAGES, 2: synchroniser flops per channel; legal range 2..8, elaboration error otherwise.
- RESET_VAL, {WIDTH{1'b0}}: WIDTH-bit reset value of the synchroniser chain and of sync_out, per channel.
- FILTER_LEN, 1: consecutive cycles the synchronised value must differ from sync_out before sync_out adopts it; legal range 1..255; 1 = no filtering.
- CNT_W, $clog2(FILTER_LEN+1), derived (localparam): filter counter width.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- async_in  input  WIDTH  asynchronous inputs, one bit per channel
- sync_out  output  WIDTH  synchronised, filtered level per channel
- rise_pulse  output  WIDTH  one-cycle strobe: sync_out bit went 0->1 on this edge
- fall_pulse  output  WIDTH  one-cycle strobe: sync_out bit went 1->0 on this edge
- any_change  output  1  OR-reduce of rise_pulse|fall_pulse, same cycle

Behaviour:
- Reset: rst sampled high at a clk edge sets:
  - all chain stages to RESET_VAL;
  - sync_out to RESET_VAL;
  - all filter counters to 0;
  - rise_pulse, fall_pulse and any_change to 0.
  Reset overrides all other updates on that edge. Reset mid-filter discards the partial count. No output glitches on reset release.
- Chain, per channel:
  - stage[0] <= async_in;
  - stage[k] <= stage[k-1];
  - raw = stage[STAGES-1].
  No logic between stages.
- Filter, per channel, evaluated each edge with rst low:
  - raw == sync_out: cnt <= 0, sync_out holds.
  - raw != sync_out and cnt == FILTER_LEN-1: sync_out <= raw, cnt <= 0.
  - raw != sync_out otherwise: cnt <= cnt+1.
- Latency: input stable before edge 1 gives raw valid after edge STAGES and sync_out updated after edge STAGES+FILTER_LEN. Minimum is 3 cycles (STAGES=2, FILTER_LEN=1).
- Glitch rejection: any raw deviation lasting fewer than FILTER_LEN cycles never reaches sync_out. The counter restarts from 0 on the first cycle raw matches sync_out again.
- Edge pulses are registered in the same always block as sync_out and are high for exactly the cycle in which the new sync_out value is visible:
  - rise_pulse[i] = 1 iff sync_out[i] changed 0->1 on this edge;
  - fall_pulse[i] = 1 iff it changed 1->0.
  - Pulses never overlap on one channel.
  - Minimum spacing between pulses on one channel is FILTER_LEN cycles.
- any_change is registered, coincident with the pulses.
- Channels are fully independent; simultaneous changes on several channels give simultaneous pulses.
- No pulse is generated by reset itself, including when RESET_VAL differs from the pre-reset sync_out.
- Counter never exceeds FILTER_LEN-1, so no wrap is possible.
- rst must be synchronous to clk. async_in has no timing relation to clk.

Test Plan:
- WIDTH=4, STAGES=3, FILTER_LEN=4, RESET_VAL=4'b0101; assert rst 2 cycles with async_in=4'b1010 -> sync_out=4'b0101, all pulses 0, any_change 0 during and after reset until the filter elapses.
- After reset, async_in=4'b0111 held from before edge 1 -> sync_out stays 0101 through edge 6; becomes 0111 after edge 7; rise_pulse=4'b0010 and any_change=1 for that cycle only.
- Channel 0 driven low for 3 cycles, then back high -> sync_out unchanged, no pulses. Repeat with 4 cycles low -> sync_out[0] falls 7 cycles after first sample; fall_pulse[0] one cycle; rises again 7 cycles after restore.
- Channels 2 and 3 toggled on the same edge (0->1 and 1->0) -> rise_pulse=4'b0100 and fall_pulse=4'b1000 in the same cycle.
- Assert rst while a channel's cnt=2 -> after release, sync_out=RESET_VAL and the filter restarts from 0; full STAGES+FILTER_LEN latency is observed.
- STAGES=2, FILTER_LEN=1, WIDTH=1 -> 0->1 step appears at sync_out after edge 3 with a one-cycle rise_pulse; alternating input every 4 cycles gives a pulse every 4 cycles.
